// File: rtl/clint_timer_pkg.sv
// Shared definitions for the CLINT machine timer: dbus types, register word offsets,
// CTRL layout and the byte-lane merge helper.
package clint_timer_pkg;

    typedef logic [31:0] MemAddrBus;
    typedef logic [31:0] MemDataBus;
    localparam int unsigned DBUS_MASK = 32'd4;

    // Word offsets, i.e. byte offset >> 2 within the 64-byte window
    localparam logic [3:0] TMR_OFF_MTIME_LO = 4'h0;
    localparam logic [3:0] TMR_OFF_MTIME_HI = 4'h1;
    localparam logic [3:0] TMR_OFF_CMP_LO   = 4'h2;
    localparam logic [3:0] TMR_OFF_CMP_HI   = 4'h3;
    localparam logic [3:0] TMR_OFF_CTRL     = 4'h4;

    localparam int unsigned CTRL_CNT_EN = 32'd0;
    localparam int unsigned CTRL_IRQ_EN = 32'd1;
    localparam logic [1:0]  CTRL_RST    = 2'b01;

    function automatic MemDataBus merge_bytes(input MemDataBus old_val,
                                              input MemDataBus new_val,
                                              input logic [DBUS_MASK-1:0] mask);
        MemDataBus res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = mask[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Divides clk by div while enabled; tick is high in the last count of each period.
module timer_prescaler (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [15:0] div,
    output logic        tick
);

    logic [15:0] cnt_r;
    logic        wrap_s;

    assign wrap_s = (cnt_r == (div - 16'd1));
    assign tick   = enable && wrap_s;

    // Period counter, frozen while disabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= 16'd0;
        end else if (enable) begin
            cnt_r <= wrap_s ? 16'd0 : (cnt_r + 16'd1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/clint_timer.sv
// Memory-mapped machine timer (mtime/mtimecmp/CTRL) with registered interrupt.
// Optional macro TIMER_SHADOW_EN adds a tear-free MTIME_HI shadow latched on MTIME_LO reads.
module clint_timer
    import clint_timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
    parameter int unsigned PRESC_DIV = 32'd1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        I_req,
    input  logic        I_we,
    input  logic [31:0] I_addr,
    input  logic [31:0] I_data,
    input  logic [3:0]  I_mask,
    output logic [31:0] O_data,
    output logic        O_ready,
    output logic        O_timer_int
);

    localparam logic [15:0] PRESC_DIV_C = PRESC_DIV[15:0];

    logic        hit_s;
    logic        wr_s;
    logic        mtime_wr_s;
    logic [3:0]  off_s;
    logic        tick_s;
    logic        unused_addr_s;
    logic [63:0] mtime_r;
    logic [63:0] mtime_nxt_s;
    logic [63:0] cmp_r;
    logic [63:0] cmp_nxt_s;
    logic [1:0]  ctrl_r;
    logic [1:0]  ctrl_nxt_s;
    MemDataBus   ctrl_word_s;
    MemDataBus   hi_rd_s;
    MemDataBus   rd_data_s;
    logic [31:0] data_r;
    logic        ready_r;
    logic        int_r;

    assign hit_s         = I_req && (I_addr[31:6] == BASE_ADDR[31:6]);
    assign off_s         = I_addr[5:2];
    assign wr_s          = hit_s && I_we;
    assign mtime_wr_s    = wr_s && (I_mask != 4'b0000) &&
                           ((off_s == TMR_OFF_MTIME_LO) || (off_s == TMR_OFF_MTIME_HI));
    assign unused_addr_s = ^I_addr[1:0];
    assign ctrl_word_s   = merge_bytes({30'd0, ctrl_r}, I_data, I_mask);

    assign O_data      = data_r;
    assign O_ready     = ready_r;
    assign O_timer_int = int_r;

    timer_prescaler u_presc (
        .clk    (clk),
        .rst    (rst),
        .enable (ctrl_r[CTRL_CNT_EN]),
        .div    (PRESC_DIV_C),
        .tick   (tick_s)
    );

`ifdef TIMER_SHADOW_EN
    logic [31:0] shadow_r;

    // Snapshot of the upper half taken by every MTIME_LO read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_r <= 32'd0;
        end else if (hit_s && !I_we && (off_s == TMR_OFF_MTIME_LO)) begin
            shadow_r <= mtime_r[63:32];
        end else begin
            shadow_r <= shadow_r;
        end
    end

    assign hi_rd_s = shadow_r;
`else
    assign hi_rd_s = mtime_r[63:32];
`endif

    // Next-state for mtime, mtimecmp and CTRL; a software write to mtime suppresses the tick
    always_comb begin
        mtime_nxt_s = mtime_r;
        cmp_nxt_s   = cmp_r;
        ctrl_nxt_s  = ctrl_r;
        if (mtime_wr_s && (off_s == TMR_OFF_MTIME_LO)) begin
            mtime_nxt_s[31:0] = merge_bytes(mtime_r[31:0], I_data, I_mask);
        end else if (mtime_wr_s) begin
            mtime_nxt_s[63:32] = merge_bytes(mtime_r[63:32], I_data, I_mask);
        end else if (tick_s) begin
            mtime_nxt_s = mtime_r + 64'd1;
        end else begin
            mtime_nxt_s = mtime_r;
        end
        if (wr_s) begin
            case (off_s)
                TMR_OFF_CMP_LO: cmp_nxt_s[31:0]  = merge_bytes(cmp_r[31:0], I_data, I_mask);
                TMR_OFF_CMP_HI: cmp_nxt_s[63:32] = merge_bytes(cmp_r[63:32], I_data, I_mask);
                TMR_OFF_CTRL:   ctrl_nxt_s       = ctrl_word_s[1:0];
                default:        ctrl_nxt_s       = ctrl_r;
            endcase
        end else begin
            ctrl_nxt_s = ctrl_r;
        end
    end

    // Read mux; unmapped offsets read as zero
    always_comb begin
        rd_data_s = 32'd0;
        case (off_s)
            TMR_OFF_MTIME_LO: rd_data_s = mtime_r[31:0];
            TMR_OFF_MTIME_HI: rd_data_s = hi_rd_s;
            TMR_OFF_CMP_LO:   rd_data_s = cmp_r[31:0];
            TMR_OFF_CMP_HI:   rd_data_s = cmp_r[63:32];
            TMR_OFF_CTRL:     rd_data_s = {30'd0, ctrl_r};
            default:          rd_data_s = 32'd0;
        endcase
    end

    // Architectural timer state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mtime_r <= 64'd0;
            cmp_r   <= 64'hFFFF_FFFF_FFFF_FFFF;
            ctrl_r  <= CTRL_RST;
        end else begin
            mtime_r <= mtime_nxt_s;
            cmp_r   <= cmp_nxt_s;
            ctrl_r  <= ctrl_nxt_s;
        end
    end

    // Bus response and interrupt; the compare sees registered values, so it lags changes by a cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_r  <= 32'd0;
            ready_r <= 1'b0;
            int_r   <= 1'b0;
        end else begin
            ready_r <= hit_s;
            data_r  <= hit_s ? (I_we ? 32'd0 : rd_data_s) : data_r;
            int_r   <= (mtime_r >= cmp_r) && ctrl_r[CTRL_IRQ_EN];
        end
    end

endmodule

// File: tb/tb_clint_timer.sv
// Scoreboard bench for clint_timer: a cycle model predicts read data and the interrupt level.
module tb_clint_timer;

    localparam logic [31:0] BASE = 32'h0200_0000;
    localparam int          DIV  = 4;
`ifdef TIMER_SHADOW_EN
    localparam bit SHADOW = 1'b1;
`else
    localparam bit SHADOW = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        I_req, I_we;
    logic [31:0] I_addr, I_data;
    logic [3:0]  I_mask;
    logic [31:0] O_data;
    logic        O_ready, O_timer_int;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    logic [63:0] m_time, m_cmp;
    logic [1:0]  m_ctrl;
    int          m_presc;
    logic        m_int;
    logic [31:0] m_shadow;

    clint_timer #(.BASE_ADDR(BASE), .PRESC_DIV(DIV)) dut (
        .clk(clk), .rst(rst), .I_req(I_req), .I_we(I_we), .I_addr(I_addr),
        .I_data(I_data), .I_mask(I_mask), .O_data(O_data), .O_ready(O_ready),
        .O_timer_int(O_timer_int)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] lanes(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = new_v[8*b +: 8];
        return r;
    endfunction

    task automatic model_reset();
        m_time = 64'd0; m_cmp = '1; m_ctrl = 2'b01; m_presc = 0; m_int = 1'b0; m_shadow = 32'd0;
        exp_q.delete();
    endtask

    // One bus cycle: drive, predict, clock, then compare
    task automatic step(input bit req, input bit we, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] mask);
        bit          hit, tick, pend;
        logic [3:0]  off;
        logic [31:0] rd, cw;
        logic [63:0] t_new;
        logic        new_int;
        I_req = req; I_we = we; I_addr = addr; I_data = data; I_mask = mask;
        hit = req && (addr[31:6] == BASE[31:6]);
        off = addr[5:2];
        rd  = 32'd0;
        if (off == 4'h0)      rd = m_time[31:0];
        else if (off == 4'h1) rd = SHADOW ? m_shadow : m_time[63:32];
        else if (off == 4'h2) rd = m_cmp[31:0];
        else if (off == 4'h3) rd = m_cmp[63:32];
        else if (off == 4'h4) rd = {30'd0, m_ctrl};
        if (hit) exp_q.push_back(we ? 32'd0 : rd);
        new_int = (m_time >= m_cmp) && m_ctrl[1];
        tick    = m_ctrl[0] && (m_presc == DIV - 1);
        if (m_ctrl[0]) m_presc = (m_presc == DIV - 1) ? 0 : m_presc + 1;
        t_new = tick ? m_time + 64'd1 : m_time;
        if (hit && !we && off == 4'h0) m_shadow = m_time[63:32];
        if (hit && we && mask != 4'b0000) begin
            case (off)
                4'h0: t_new = {m_time[63:32], lanes(m_time[31:0], data, mask)};
                4'h1: t_new = {lanes(m_time[63:32], data, mask), m_time[31:0]};
                4'h2: m_cmp[31:0]  = lanes(m_cmp[31:0], data, mask);
                4'h3: m_cmp[63:32] = lanes(m_cmp[63:32], data, mask);
                4'h4: begin cw = lanes({30'd0, m_ctrl}, data, mask); m_ctrl = cw[1:0]; end
                default: ;
            endcase
        end
        m_time = t_new;
        m_int  = new_int;
        @(posedge clk); #1;
        pend = (exp_q.size() != 0);
        check_val("ready", O_ready, pend);
        if (pend && O_ready) check_val($sformatf("data@%h", addr), O_data, exp_q.pop_front());
        else if (pend) void'(exp_q.pop_front());
        check_val("timer_int", O_timer_int, m_int);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    endtask

    task automatic rd(input logic [7:0] boff);
        step(1'b1, 1'b0, BASE + {24'd0, boff}, 32'hDEAD_BEEF, 4'hF);
    endtask

    task automatic wr(input logic [7:0] boff, input logic [31:0] d, input logic [3:0] m);
        step(1'b1, 1'b1, BASE + {24'd0, boff}, d, m);
    endtask

    initial begin
        rst = 1'b1; I_req = 1'b0; I_we = 1'b0; I_addr = 32'd0; I_data = 32'd0; I_mask = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_ready", O_ready, 1'b0);
        check_val("rst_data", O_data, 32'd0);
        check_val("rst_int", O_timer_int, 1'b0);
        rst = 1'b0;
        model_reset();

        // Reset values and prescaled counting
        rd(8'h10);
        check_val("ctrl_reset", O_data, 32'h1);
        rd(8'h0C);
        check_val("cmp_hi_reset", O_data, 32'hFFFF_FFFF);
        idle(40);
        rd(8'h00);
        check_val("mtime_after_40", (O_data >= 32'd9) && (O_data <= 32'd11), 1'b1);
        idle(1);
        check_val("ready_pulse", O_ready, 1'b0);

        // Carry from low to high half
        wr(8'h00, 32'hFFFF_FFFF, 4'hF);
        wr(8'h04, 32'h0, 4'hF);
        idle(2 * DIV);
        rd(8'h04);
        check_val("carry_hi", O_data, 32'h1);
        rd(8'h00);

        // Compare/interrupt set and clear
        wr(8'h04, 32'h0, 4'hF);
        wr(8'h00, 32'h0, 4'hF);
        wr(8'h0C, 32'h0, 4'hF);
        wr(8'h08, 32'd100, 4'hF);
        wr(8'h10, 32'h3, 4'hF);
        idle(100 * DIV + 8);
        check_val("int_set", O_timer_int, 1'b1);
        wr(8'h08, 32'd200, 4'hF);
        idle(1);
        check_val("int_clear", O_timer_int, 1'b0);

        // Byte masks, mask zero, unmapped and out-of-window accesses
        wr(8'h08, 32'hFFFF_FFFF, 4'hF);
        wr(8'h08, 32'hAABB_CCDD, 4'b0010);
        rd(8'h08);
        check_val("masked_cmp", O_data, 32'hFFFF_CCFF);
        wr(8'h08, 32'h1234_5678, 4'b0000);
        rd(8'h08);
        step(1'b1, 1'b0, BASE + 32'h40, 32'd0, 4'hF);
        step(1'b1, 1'b1, BASE + 32'h40, 32'd0, 4'hF);
        rd(8'h14);
        wr(8'h3C, 32'hFFFF_FFFF, 4'hF);
        rd(8'h3C);
        rd(8'h0B);

        // Counter freeze
        wr(8'h10, 32'h0, 4'hF);
        rd(8'h00);
        idle(20);
        rd(8'h00);
        wr(8'h10, 32'h1, 4'hF);
        idle(DIV * 3);
        rd(8'h00);

        // Tear-free read (shadow when enabled, live value otherwise)
        wr(8'h04, 32'h5, 4'hF);
        wr(8'h00, 32'hFFFF_FFF0, 4'hF);
        rd(8'h00);
        idle(100);
        rd(8'h04);
        rd(8'h00);

        // Reset in the middle of a response
        wr(8'h0C, 32'h0, 4'hF);
        wr(8'h08, 32'h0, 4'hF);
        wr(8'h10, 32'h3, 4'hF);
        idle(3);
        rd(8'h10);
        rst = 1'b1;
        #1;
        check_val("midrst_ready", O_ready, 1'b0);
        check_val("midrst_data", O_data, 32'd0);
        check_val("midrst_int", O_timer_int, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        rd(8'h00);
        check_val("mtime_after_rst", O_data, 32'd0);
        rd(8'h04);
        rd(8'h10);
        rd(8'h08);
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/clint_timer.md
Name: clint_timer

Overview:
- Memory-mapped machine timer on the core's data bus, between the dbus port and the interrupt input vector.
- Holds a 64-bit free-running `mtime`, a 64-bit `mtimecmp` and a control register.
- Produces the registered `timer_int` that drives bit 0 of the core interrupt vector.
- Answers dbus accesses inside its window with a one-cycle `ready` handshake; accesses outside the window get no response.

Parameters:
- BASE_ADDR, 32'h0200_0000, byte base address of the register window (64-byte aligned).
- PRESC_DIV, 1, clock cycles per `mtime` increment; legal range 1..65535.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-high.
- I_req  input  1  dbus request valid.
- I_we  input  1  write enable, qualified by I_req.
- I_addr  input  32  byte address.
- I_data  input  32  write data.
- I_mask  input  4  byte-lane write mask (`DBUS_MASK` wide); bit n enables byte n.
- O_data  output  32  read data, valid when O_ready=1.
- O_ready  output  1  access completion pulse.
- O_timer_int  output  1  machine timer interrupt, level.

Behaviour:
- Hit condition: I_req && I_addr[31:6]==BASE_ADDR[31:6]. Register offset is I_addr[5:2]; I_addr[1:0] is ignored.
- Register map (offset in bytes):
  - 0x00 MTIME_LO, 0x04 MTIME_HI.
  - 0x08 MTIMECMP_LO, 0x0C MTIMECMP_HI.
  - 0x10 CTRL: bit0 CNT_EN, bit1 IRQ_EN; other bits read 0.
- Unmapped offsets inside the window: reads return 0, writes are dropped, O_ready still pulses.
- Reset values:
  - mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, CTRL=2'b01.
  - prescaler=0, O_data=0, O_ready=0, O_timer_int=0.
- Handshake:
  - A hit in cycle N gives O_ready=1 in cycle N+1, with O_data holding the read value sampled at cycle N. O_data is 0 for writes.
  - O_ready is a single-cycle pulse. Back-to-back hits give back-to-back pulses.
  - No hit in cycle N gives O_ready=0 in N+1. O_data holds its last value.
- Write timing: writes take effect at the clock edge that ends cycle N. Each byte is updated only where its I_mask bit is 1; I_mask=0 means no update.
- Prescaler: counts 0..PRESC_DIV-1 while CNT_EN=1. When it wraps, mtime increments by 1. With PRESC_DIV=1, mtime increments every cycle.
- CNT_EN=0 freezes both the prescaler and mtime.
- mtime wraps from 64'hFFFF_FFFF_FFFF_FFFF to 0 with no flag.
- Simultaneous events:
  - A software write to an MTIME half wins over the increment in the same cycle for the written bytes.
  - Unwritten bytes keep their pre-increment value; no carry is applied to them in that cycle.
- Interrupt: O_timer_int is registered as (mtime >= mtimecmp) && IRQ_EN, using the post-update values. It therefore reflects the state one cycle after any change, with 64-bit unsigned compare.
- Interrupt clear: writing mtimecmp above mtime deasserts O_timer_int on the following cycle.
- Reset mid-access: asynchronous rst clears all state immediately. An in-flight O_ready is dropped.

Optional Feature:
- Macro: TIMER_SHADOW_EN.
- Defined:
  - A read of MTIME_LO also latches mtime[63:32] into a 32-bit shadow register.
  - Subsequent MTIME_HI reads return the shadow, which gives a tear-free 64-bit read.
  - The shadow resets to 0 and is reloaded only by MTIME_LO reads.
- Not defined: MTIME_HI reads return live mtime[63:32] and no shadow register exists.

Decomposition:
- Shared package/defines header holds:
  - register offsets: TMR_OFF_MTIME_LO/HI, TMR_OFF_CMP_LO/HI, TMR_OFF_CTRL;
  - CTRL bit indices and CTRL reset value;
  - reuse of existing `MemAddrBus`, `MemDataBus`, `DBUS_MASK`.
- Sub-module `timer_prescaler`: inputs clk, rst, enable, div; output a one-cycle tick. It contains the only counter besides mtime.

Test Plan:
- Reset, then read CTRL and MTIMECMP_HI -> O_ready at N+1; data 32'h1, then 32'hFFFF_FFFF; O_timer_int=0.
- PRESC_DIV=4, CNT_EN=1, wait 40 cycles, read MTIME_LO -> 10 (±1 for the read cycle); O_ready high for exactly 1 cycle.
- Write MTIME_LO=32'hFFFF_FFFF, MTIME_HI=0, wait 1 tick -> MTIME_HI=1, MTIME_LO=0 (carry across halves).
- CTRL=3, MTIMECMP={0,100}, run until mtime=100 -> O_timer_int rises exactly one cycle after mtime reaches 100. Then write MTIMECMP_LO=200 -> O_timer_int falls the next cycle.
- Byte-masked write I_mask=4'b0010, data 32'hAABB_CCDD to MTIMECMP_LO (cmp_lo was 32'hFFFF_FFFF) -> reads back 32'hFFFF_CCFF. Access to BASE_ADDR+0x40 -> no O_ready.
- Assert rst in the cycle after a hit -> O_ready, O_data and O_timer_int are 0 immediately and mtime=0. Under TIMER_SHADOW_EN: read LO, let HI change, read HI -> returns the latched value.
